// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch sequencer
//
// Walks the fetch of one instruction at a time: request a read at the current
// program counter, capture the returned word, present it downstream until it
// is accepted, then pulse the program counter forward and repeat. Fetching a
// word whose opcode equals HALT_OP parks the block in HALT until reset.
//
// Ports
//   clk          in   clock, rising edge active
//   reset        in   synchronous active-low reset
//   start        in   begin fetching (looked at only in IDLE)
//   pc_addr      in   current program-counter value
//   wr_pc        out  one-cycle pulse: advance the program counter
//   imem_addr    out  instruction-memory read address
//   imem_rd      out  instruction-memory read strobe
//   imem_data    in   read data, valid the cycle after imem_rd
//   instr        out  captured instruction
//   instr_valid  out  instr not yet accepted
//   instr_ready  in   downstream accepts instr when instr_valid is high
//   halted       out  HALT_OP was fetched
//   instr_count  out  saturating count of accepted instructions
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int          ADDR_W  = 11,
    parameter int          INSTR_W = 16,
    parameter logic [4:0]  HALT_OP = 5'b00000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               wr_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted,
    output logic [ADDR_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ADV  = 3'd4,
        HALT = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_capture;
    logic                 w_count_inc;
    logic                 r_wr_pc;
    logic                 r_imem_rd;
    logic                 r_instr_valid;
    logic                 r_halted;
    logic [ADDR_W-1:0]    r_last_addr;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_instr_count;
    logic [4:0]           w_opcode;

    assign w_opcode = imem_data[INSTR_W-1 -: 5];

    // Next-state decode plus the capture / count-enable strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_count_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_capture = 1'b1;
                if (w_opcode == HALT_OP) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_state_nxt = ADV;
                    w_count_inc = 1'b1;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            ADV: begin
                w_state_nxt = REQ;
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered outputs; strobes are decoded from the
    // next state so each one is high exactly while the FSM sits in its state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_wr_pc       <= 1'b0;
            r_imem_rd     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_last_addr   <= {ADDR_W{1'b0}};
            r_instr       <= {INSTR_W{1'b0}};
            r_instr_count <= {ADDR_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_wr_pc       <= (w_state_nxt == ADV);
            r_imem_rd     <= (w_state_nxt == REQ);
            r_instr_valid <= (w_state_nxt == HOLD);
            r_halted      <= (w_state_nxt == HALT);
            if (r_state == REQ) begin
                r_last_addr <= pc_addr;
            end else begin
                r_last_addr <= r_last_addr;
            end
            if (w_capture) begin
                r_instr <= imem_data;
            end else begin
                r_instr <= r_instr;
            end
            if (w_count_inc && (r_instr_count != CNT_MAX)) begin
                r_instr_count <= r_instr_count + CNT_ONE;
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    // The PC advances on the same edge that enters REQ, so the read address
    // must follow pc_addr live during REQ; registering it would present the
    // pre-advance value.
    assign imem_addr   = (r_state == REQ) ? pc_addr : r_last_addr;
    assign wr_pc       = r_wr_pc;
    assign imem_rd     = r_imem_rd;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int AW = 11;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] pc_addr;
    logic          wr_pc;
    logic [AW-1:0] imem_addr;
    logic          imem_rd;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          halted;
    logic [AW-1:0] instr_count;

    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic [IW-1:0] mem [0:2047];

    logic          mon_clr;
    int            cnt_wr;
    int            cnt_rd;
    int            cnt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .HALT_OP(5'b00000)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_addr     (pc_addr),
        .wr_pc       (wr_pc),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Program counter: advances on wr_pc, loadable by the bench.
    always @(posedge clk) begin
        if (pc_load) pc_addr <= pc_load_val;
        else if (wr_pc) pc_addr <= pc_addr + 11'd1;
    end

    // Instruction memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    // Strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_clr) begin
            cnt_wr <= 0; cnt_rd <= 0; cnt_valid <= 0;
        end else begin
            if (wr_pc)       cnt_wr    <= cnt_wr + 1;
            if (imem_rd)     cnt_rd    <= cnt_rd + 1;
            if (instr_valid) cnt_valid <= cnt_valid + 1;
        end
    end

    typedef struct {
        logic          rst_n;
        logic          st;
        logic          rdy;
        logic          e_rd;
        logic          e_wr;
        logic          e_valid;
        logic          e_halt;
        logic [AW-1:0] e_addr;
        logic [AW-1:0] e_cnt;
        logic [IW-1:0] e_instr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [AW-1:0] pcv);
        reset = 1'b0; start = 1'b0; instr_ready = 1'b0;
        pc_load = 1'b1; pc_load_val = pcv; mon_clr = 1'b1;
        step();
        reset = 1'b1; pc_load = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic load_seq_prog();
        mem[0] = 16'h0801;
        mem[1] = 16'h1002;
        mem[2] = 16'h0000;
    endtask

    // Transaction-level reference: instructions must be accepted in address
    // order, one read and one PC pulse per instruction, count saturating.
    task automatic run_model(input int halt_at, input int stop_after);
        int   acc;
        int   cyc;
        logic prev_hs;
        acc = 0; cyc = 0; prev_hs = 1'b0;
        start = 1'b1;
        step();
        while (cyc < 40000) begin
            check("rnd.wr", wr_pc, prev_hs);
            check("rnd.cnt", instr_count, (acc > 2047) ? 2047 : acc);
            if (imem_rd) check("rnd.addr", imem_addr, acc % 2048);
            if (instr_valid) begin
                check("rnd.instr", instr, mem[acc % 2048]);
                check("rnd.nohaltvalid", instr[15:11] == 5'd0, 1'b0);
            end
            if (halted) begin
                check("rnd.haltpos", acc, halt_at);
                break;
            end
            if (acc == stop_after) break;
            instr_ready = ($urandom_range(0, 3) != 0);
            start       = $urandom_range(0, 1) != 0;
            prev_hs     = instr_valid && instr_ready;
            if (prev_hs) acc++;
            step();
            cyc++;
        end
        if (cyc >= 40000) fail_now("rnd.timeout");
        start = 1'b0;
        if (halt_at >= 0) begin
            check("rnd.halted", halted, 1'b1);
            check("rnd.pc", pc_addr, halt_at);
            check("rnd.reads", cnt_rd, halt_at + 1);
            check("rnd.wrs", cnt_wr, halt_at);
        end else begin
            check("rnd.sat", instr_count, 2047);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 16'h0801};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd1, 16'h0801};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1, 11'd1, 16'h0801};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd1, 11'd1, 16'h0801};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1, 11'd1, 16'h1002};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd1, 11'd2, 16'h1002};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd2, 11'd2, 16'h1002};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2, 11'd2, 16'h1002};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2, 11'd2, 16'h0000};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2, 11'd2, 16'h0000};

        // Sequential fetch, cycle by cycle.
        load_seq_prog();
        apply_reset(11'd0);
        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst_n; start = tbl[i].st; instr_ready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d.rd", i),    imem_rd,     tbl[i].e_rd);
            check($sformatf("vec%0d.wr", i),    wr_pc,       tbl[i].e_wr);
            check($sformatf("vec%0d.valid", i), instr_valid, tbl[i].e_valid);
            check($sformatf("vec%0d.halt", i),  halted,      tbl[i].e_halt);
            check($sformatf("vec%0d.addr", i),  imem_addr,   tbl[i].e_addr);
            check($sformatf("vec%0d.cnt", i),   instr_count, tbl[i].e_cnt);
            check($sformatf("vec%0d.instr", i), instr,       tbl[i].e_instr);
        end
        start = 1'b0;
        check("seq.pc", pc_addr, 2);
        check("seq.wrpulses", cnt_wr, 2);

        // Backpressure in HOLD.
        apply_reset(11'd0);
        start = 1'b1; step(); start = 1'b0; step(); step();
        check("bp.enter", instr_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp%0d.valid", i), instr_valid, 1'b1);
            check($sformatf("bp%0d.instr", i), instr, 16'h0801);
            check($sformatf("bp%0d.wr", i),    wr_pc, 1'b0);
            check($sformatf("bp%0d.rd", i),    imem_rd, 1'b0);
        end
        instr_ready = 1'b1;
        step();
        check("bp.wr", wr_pc, 1'b1);
        step();
        check("bp.rd", imem_rd, 1'b1);
        check("bp.addr", imem_addr, 1);

        // Halt as the very first instruction.
        mem[0] = 16'h0000;
        apply_reset(11'd0);
        instr_ready = 1'b1;
        start = 1'b1; step();
        check("h1.rd", imem_rd, 1'b1);
        start = 1'b0; step();
        check("h1.c2", halted, 1'b0);
        step();
        check("h1.c3", halted, 1'b1);
        start = 1'b1; step(); start = 1'b0; step(); step();
        check("h1.stay", halted, 1'b1);
        check("h1.rdnow", imem_rd, 1'b0);
        check("h1.wrs", cnt_wr, 0);
        check("h1.valids", cnt_valid, 0);
        check("h1.reads", cnt_rd, 1);
        check("h1.pc", pc_addr, 0);

        // Reset during WAIT, then refetch from a moved PC.
        load_seq_prog();
        apply_reset(11'd0);
        start = 1'b1; step(); start = 1'b0; step();
        reset = 1'b0; step();
        check("rst.rd", imem_rd, 1'b0);
        check("rst.wr", wr_pc, 1'b0);
        check("rst.valid", instr_valid, 1'b0);
        check("rst.halt", halted, 1'b0);
        check("rst.addr", imem_addr, 0);
        check("rst.cnt", instr_count, 0);
        check("rst.instr", instr, 0);
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 11'd1; step(); pc_load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check("rst.refetch_rd", imem_rd, 1'b1);
        check("rst.refetch_addr", imem_addr, 1);
        step(); step();
        check("rst.refetch_instr", instr, 16'h1002);
        check("rst.refetch_valid", instr_valid, 1'b1);

        // Start held high for a whole run.
        apply_reset(11'd0);
        instr_ready = 1'b1; start = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) step();
        start = 1'b0;
        if (!halted) fail_now("sh.halt");
        check("sh.reads", cnt_rd, 3);
        check("sh.wrs", cnt_wr, 2);
        check("sh.cnt", instr_count, 2);
        check("sh.pc", pc_addr, 2);

        // Random short programs ending in a halt.
        for (int it = 0; it < 6; it++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int a = 0; a < len; a++)
                mem[a] = {5'($urandom_range(1, 31)), 11'($urandom())};
            mem[len] = {5'b00000, 11'($urandom())};
            apply_reset(11'd0);
            run_model(len, -1);
        end

        // Long random run with no halt: counter saturation.
        for (int a = 0; a < 2048; a++)
            mem[a] = {5'($urandom_range(1, 31)), 11'($urandom())};
        apply_reset(11'd0);
        run_model(-1, 2050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
